// File: rtl/battleship_turn_ctrl_pkg.sv
// Shared types and constants for the battleship turn controller:
// board cell encoding, FSM states, board geometry and a cursor helper.
package battleship_pkg;

  localparam int BOARD_DIM = 8;
  localparam int COORD_W   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIP  = 2'b01,
    HIT   = 2'b10,
    MISS  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    P_WAIT,
    P_READ,
    P_EVAL,
    C_WAIT,
    C_READ,
    C_EVAL,
    GAME_OVER
  } state_t;

  // Move one coordinate a single step, clamping at the board edges.
  function automatic logic [COORD_W-1:0] coord_step(input logic [COORD_W-1:0] c,
                                                     input logic               up);
    logic [COORD_W-1:0] r;
    r = c;
    if (up) begin
      if (c != COORD_W'(BOARD_DIM - 1)) r = c + 1'b1;
    end else begin
      if (c != '0) r = c - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/battleship_turn_ctrl_if.sv
// CPU coordinate handshake plus the dual-board RAM port.
// master = turn controller, slave = CPU picker / board RAM side.
interface battleship_turn_ctrl_if;
  import battleship_pkg::*;

  logic [COORD_W-1:0]   cpu_x;
  logic [COORD_W-1:0]   cpu_y;
  logic                 cpu_valid;
  logic                 cpu_req;
  logic                 board_sel;
  logic [2*COORD_W-1:0] board_addr;
  cell_t                board_rd_data;
  logic                 board_wr_en;
  cell_t                board_wr_data;

  modport master (
    input  cpu_x, cpu_y, cpu_valid, board_rd_data,
    output cpu_req, board_sel, board_addr, board_wr_en, board_wr_data
  );

  modport slave (
    output cpu_x, cpu_y, cpu_valid, board_rd_data,
    input  cpu_req, board_sel, board_addr, board_wr_en, board_wr_data
  );

endinterface

// File: rtl/battleship_turn_ctrl_button_edge.sv
// Active-low push button conditioner: 2-FF synchronizer followed by a
// falling-edge detector giving one pulse per press, none while held.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_pin_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the raw pin and keep last synchronized level; released = 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_pin_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_prev & ~r_sync2;

endmodule

// File: rtl/battleship_turn_ctrl.sv
// Turn sequencer for 8x8 battleship: player cursor, shot arbitration on
// the shared board RAM, remaining-ship bookkeeping and winner detection.
module battleship_turn_ctrl
  import battleship_pkg::*;
#(
  parameter int SHIP_CELLS  = 5,
  parameter int TURN_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  attack,
  input  logic                  izquierda,
  input  logic                  arriba,
  input  logic                  abajo,
  input  logic                  derecha,
  battleship_turn_ctrl_if.master bus,
  output logic [COORD_W-1:0]    posicion_x,
  output logic [COORD_W-1:0]    posicion_y,
  output logic [2:0]            barcos_jugador,
  output logic [2:0]            barcos_cpu,
  output logic                  turn,
  output logic                  game_over,
  output logic                  winner
);

  localparam int               CNT_W      = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [2:0]       SHIPS_INIT = 3'(SHIP_CELLS);

  logic w_attack;
  logic w_left;
  logic w_up;
  logic w_down;
  logic w_right;

  button_edge u_btn_attack (.clk(clk), .reset(reset), .i_pin_n(attack),    .o_press(w_attack));
  button_edge u_btn_left   (.clk(clk), .reset(reset), .i_pin_n(izquierda), .o_press(w_left));
  button_edge u_btn_up     (.clk(clk), .reset(reset), .i_pin_n(arriba),    .o_press(w_up));
  button_edge u_btn_down   (.clk(clk), .reset(reset), .i_pin_n(abajo),     .o_press(w_down));
  button_edge u_btn_right  (.clk(clk), .reset(reset), .i_pin_n(derecha),   .o_press(w_right));

  state_t             r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [2:0]         r_ships_player;
  logic [2:0]         r_ships_cpu;
  logic [CNT_W-1:0]   r_idle;
  logic               r_turn;
  logic               r_game_over;
  logic               r_winner;
  logic               w_wr_en;
  cell_t              w_wr_data;

  // Write strobe depends on the RAM data of the current EVAL cycle, so it
  // is decoded from state and read data rather than registered.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = EMPTY;
    if (r_state == P_EVAL || r_state == C_EVAL) begin
      if (bus.board_rd_data == EMPTY) begin
        w_wr_en   = 1'b1;
        w_wr_data = MISS;
      end else if (bus.board_rd_data == SHIP) begin
        w_wr_en   = 1'b1;
        w_wr_data = HIT;
      end
    end
  end

  // Turn FSM with registered outputs; address/select hold from READ to EVAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= P_WAIT;
      r_x            <= '0;
      r_y            <= '0;
      r_ships_player <= SHIPS_INIT;
      r_ships_cpu    <= SHIPS_INIT;
      r_idle         <= '0;
      r_turn         <= 1'b0;
      r_game_over    <= 1'b0;
      r_winner       <= 1'b0;
      bus.cpu_req    <= 1'b0;
      bus.board_sel  <= 1'b0;
      bus.board_addr <= '0;
    end else begin
      case (r_state)
        P_WAIT: begin
          if (w_attack) begin
            r_state        <= P_READ;
            bus.board_sel  <= 1'b1;
            bus.board_addr <= {r_y, r_x};
          end else if (r_idle == IDLE_LAST) begin
            r_state     <= C_WAIT;
            r_turn      <= 1'b1;
            bus.cpu_req <= 1'b1;
          end else begin
            r_idle <= r_idle + 1'b1;
            if (w_left)       r_x <= coord_step(r_x, 1'b0);
            else if (w_right) r_x <= coord_step(r_x, 1'b1);
            else if (w_up)    r_y <= coord_step(r_y, 1'b0);
            else if (w_down)  r_y <= coord_step(r_y, 1'b1);
          end
        end
        P_READ: r_state <= P_EVAL;
        P_EVAL: begin
          case (bus.board_rd_data)
            EMPTY: begin
              r_state     <= C_WAIT;
              r_turn      <= 1'b1;
              bus.cpu_req <= 1'b1;
            end
            SHIP: begin
              r_ships_cpu <= r_ships_cpu - 3'd1;
              if (r_ships_cpu == 3'd1) begin
                r_state     <= GAME_OVER;
                r_game_over <= 1'b1;
                r_winner    <= 1'b0;
              end else begin
                r_state     <= C_WAIT;
                r_turn      <= 1'b1;
                bus.cpu_req <= 1'b1;
              end
            end
            default: begin
              r_state <= P_WAIT;
              r_idle  <= '0;
            end
          endcase
        end
        C_WAIT: begin
          if (bus.cpu_req && bus.cpu_valid) begin
            r_state        <= C_READ;
            bus.cpu_req    <= 1'b0;
            bus.board_sel  <= 1'b0;
            bus.board_addr <= {bus.cpu_y, bus.cpu_x};
          end
        end
        C_READ: r_state <= C_EVAL;
        C_EVAL: begin
          case (bus.board_rd_data)
            EMPTY: begin
              r_state <= P_WAIT;
              r_turn  <= 1'b0;
              r_idle  <= '0;
            end
            SHIP: begin
              r_ships_player <= r_ships_player - 3'd1;
              if (r_ships_player == 3'd1) begin
                r_state     <= GAME_OVER;
                r_game_over <= 1'b1;
                r_winner    <= 1'b1;
              end else begin
                r_state <= P_WAIT;
                r_turn  <= 1'b0;
                r_idle  <= '0;
              end
            end
            default: begin
              r_state     <= C_WAIT;
              bus.cpu_req <= 1'b1;
            end
          endcase
        end
        GAME_OVER: r_state <= GAME_OVER;
        default:   r_state <= P_WAIT;
      endcase
    end
  end

  assign bus.board_wr_en   = w_wr_en;
  assign bus.board_wr_data = w_wr_data;
  assign posicion_x        = r_x;
  assign posicion_y        = r_y;
  assign barcos_jugador    = r_ships_player;
  assign barcos_cpu        = r_ships_cpu;
  assign turn              = r_turn;
  assign game_over         = r_game_over;
  assign winner            = r_winner;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed bench for battleship_turn_ctrl with a small dual-board RAM model.
module tb_battleship_turn_ctrl;
  import battleship_pkg::*;

  localparam int TC = 16;
  localparam int SC = 2;
  localparam logic [4:0] M_A = 5'b00001;
  localparam logic [4:0] M_L = 5'b00010;
  localparam logic [4:0] M_U = 5'b00100;
  localparam logic [4:0] M_D = 5'b01000;
  localparam logic [4:0] M_R = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_n;
  logic [2:0] px, py, bj, bc;
  logic       turn, game_over, winner;

  battleship_turn_ctrl_if bus();

  battleship_turn_ctrl #(.SHIP_CELLS(SC), .TURN_CYCLES(TC)) dut (
    .clk(clk), .reset(reset),
    .attack(btn_n[0]), .izquierda(btn_n[1]), .arriba(btn_n[2]),
    .abajo(btn_n[3]), .derecha(btn_n[4]),
    .bus(bus),
    .posicion_x(px), .posicion_y(py),
    .barcos_jugador(bj), .barcos_cpu(bc),
    .turn(turn), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  cell_t      mem [0:1][0:63];
  int         wr_count  = 0;
  logic       last_sel  = 1'b0;
  logic [5:0] last_addr = '0;
  cell_t      last_data = EMPTY;
  int         total = 0;
  int         bad   = 0;

  // Synchronous-read RAM model; writes are logged, contents stay as loaded.
  always @(posedge clk) begin
    bus.board_rd_data <= mem[bus.board_sel][bus.board_addr];
    if (bus.board_wr_en) begin
      wr_count  <= wr_count + 1;
      last_sel  <= bus.board_sel;
      last_addr <= bus.board_addr;
      last_data <= bus.board_wr_data;
    end
  end

  task automatic clear_mem();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 64; a++) mem[b][a] = EMPTY;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; btn_n = '1; bus.cpu_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Press (and release) the masked buttons; returns right after the DUT acts.
  task automatic press(input logic [4:0] m);
    btn_n = ~m;
    @(negedge clk);
    btn_n = '1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic serve_cpu(input logic [2:0] x, input logic [2:0] y);
    int n;
    n = 0;
    while (bus.cpu_req !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    total++; if (bus.cpu_req !== 1'b1) begin bad++; $display("FAIL serve_cpu_req got=%b exp=1", bus.cpu_req); end
    bus.cpu_x = x; bus.cpu_y = y; bus.cpu_valid = 1'b1;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_n = '1; bus.cpu_valid = 1'b0; bus.cpu_x = '0; bus.cpu_y = '0;
    clear_mem();
    repeat (2) @(negedge clk);
    total++; if (px !== 3'd0) begin bad++; $display("FAIL rst_x got=%0d exp=0", px); end
    total++; if (py !== 3'd0) begin bad++; $display("FAIL rst_y got=%0d exp=0", py); end
    total++; if (bj !== 3'd2) begin bad++; $display("FAIL rst_barcos_j got=%0d exp=2", bj); end
    total++; if (bc !== 3'd2) begin bad++; $display("FAIL rst_barcos_cpu got=%0d exp=2", bc); end
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL rst_turn got=%b exp=0", turn); end
    total++; if (bus.cpu_req !== 1'b0) begin bad++; $display("FAIL rst_cpu_req got=%b exp=0", bus.cpu_req); end
    total++; if (bus.board_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.board_wr_en); end
    total++; if (bus.board_sel !== 1'b0) begin bad++; $display("FAIL rst_sel got=%b exp=0", bus.board_sel); end
    total++; if (bus.board_addr !== 6'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bus.board_addr); end
    total++; if (bus.board_wr_data !== EMPTY) begin bad++; $display("FAIL rst_wr_data got=%0d exp=0", bus.board_wr_data); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over got=%b exp=0", game_over); end
    total++; if (winner !== 1'b0) begin bad++; $display("FAIL rst_winner got=%b exp=0", winner); end
  endtask

  task automatic test_cursor();
    do_reset();
    repeat (3) press(M_L);
    total++; if (px !== 3'd0) begin bad++; $display("FAIL left_sat_x got=%0d exp=0", px); end
    press(M_U);
    total++; if (py !== 3'd0) begin bad++; $display("FAIL up_sat_y got=%0d exp=0", py); end
    // Nine fast presses from a fresh reset; the turn times out after 16 cycles.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      btn_n = ~M_R; @(negedge clk);
      btn_n = '1;   @(negedge clk);
    end
    @(negedge clk);
    total++; if (px !== 3'd7) begin bad++; $display("FAIL right_burst_x got=%0d exp=7", px); end
    total++; if (turn !== 1'b1) begin bad++; $display("FAIL burst_timeout_turn got=%b exp=1", turn); end
    serve_cpu(3'd0, 3'd0);
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL back_to_player got=%b exp=0", turn); end
    press(M_R);
    total++; if (px !== 3'd7) begin bad++; $display("FAIL right_sat_x got=%0d exp=7", px); end
    press(M_L | M_U);
    total++; if (px !== 3'd6 || py !== 3'd0) begin bad++; $display("FAIL prio_left_up got=(%0d,%0d) exp=(6,0)", px, py); end
    press(M_D);
    total++; if (py !== 3'd1) begin bad++; $display("FAIL down_y got=%0d exp=1", py); end
  endtask

  task automatic test_attack_hit();
    int c0;
    clear_mem(); mem[1][10] = SHIP;
    do_reset();
    press(M_R); press(M_R); press(M_D);
    total++; if (px !== 3'd2 || py !== 3'd1) begin bad++; $display("FAIL hit_cursor got=(%0d,%0d) exp=(2,1)", px, py); end
    c0 = wr_count;
    press(M_A);
    total++; if (bus.board_addr !== 6'd10 || bus.board_sel !== 1'b1) begin bad++; $display("FAIL hit_read addr=%0d sel=%b exp addr=10 sel=1", bus.board_addr, bus.board_sel); end
    total++; if (bus.board_wr_en !== 1'b0) begin bad++; $display("FAIL hit_read_wr got=%b exp=0", bus.board_wr_en); end
    @(negedge clk);
    total++; if (bus.board_wr_en !== 1'b1 || bus.board_wr_data !== HIT) begin bad++; $display("FAIL hit_eval wr=%b data=%0d exp wr=1 data=2", bus.board_wr_en, bus.board_wr_data); end
    @(negedge clk);
    total++; if (bc !== 3'd1) begin bad++; $display("FAIL hit_barcos_cpu got=%0d exp=1", bc); end
    total++; if (turn !== 1'b1 || bus.cpu_req !== 1'b1) begin bad++; $display("FAIL hit_turn turn=%b req=%b exp 1 1", turn, bus.cpu_req); end
    total++; if (wr_count !== c0 + 1 || last_addr !== 6'd10 || last_sel !== 1'b1) begin bad++; $display("FAIL hit_log cnt=%0d addr=%0d sel=%b exp cnt=%0d addr=10 sel=1", wr_count, last_addr, last_sel, c0 + 1); end
  endtask

  task automatic test_repeat_miss();
    int c0;
    clear_mem(); mem[1][0] = MISS;
    do_reset();
    c0 = wr_count;
    press(M_A);
    @(negedge clk);
    total++; if (bus.board_wr_en !== 1'b0) begin bad++; $display("FAIL repeat_wr_en got=%b exp=0", bus.board_wr_en); end
    @(negedge clk);
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL repeat_turn got=%b exp=0", turn); end
    total++; if (bc !== 3'd2 || bj !== 3'd2) begin bad++; $display("FAIL repeat_counts got=(%0d,%0d) exp=(2,2)", bc, bj); end
    press(M_R);
    total++; if (px !== 3'd1) begin bad++; $display("FAIL repeat_keeps_turn_x got=%0d exp=1", px); end
    total++; if (wr_count !== c0) begin bad++; $display("FAIL repeat_no_write got=%0d exp=%0d", wr_count, c0); end
  endtask

  task automatic test_idle_cpu();
    clear_mem();
    do_reset();
    repeat (15) @(negedge clk);
    total++; if (turn !== 1'b0 || bus.cpu_req !== 1'b0) begin bad++; $display("FAIL idle_15 turn=%b req=%b exp 0 0", turn, bus.cpu_req); end
    @(negedge clk);
    total++; if (turn !== 1'b1 || bus.cpu_req !== 1'b1) begin bad++; $display("FAIL idle_16 turn=%b req=%b exp 1 1", turn, bus.cpu_req); end
    bus.cpu_x = 3'd3; bus.cpu_y = 3'd3; bus.cpu_valid = 1'b1;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    total++; if (bus.cpu_req !== 1'b0 || bus.board_sel !== 1'b0 || bus.board_addr !== 6'd27) begin bad++; $display("FAIL cpu_read req=%b sel=%b addr=%0d exp 0 0 27", bus.cpu_req, bus.board_sel, bus.board_addr); end
    @(negedge clk);
    total++; if (bus.board_wr_en !== 1'b1 || bus.board_wr_data !== MISS) begin bad++; $display("FAIL cpu_eval wr=%b data=%0d exp wr=1 data=3", bus.board_wr_en, bus.board_wr_data); end
    @(negedge clk);
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL cpu_done_turn got=%b exp=0", turn); end
    total++; if (last_addr !== 6'd27 || last_sel !== 1'b0 || last_data !== MISS) begin bad++; $display("FAIL cpu_log addr=%0d sel=%b data=%0d exp 27 0 3", last_addr, last_sel, last_data); end
  endtask

  task automatic test_player_win();
    int c0;
    clear_mem(); mem[1][0] = SHIP; mem[1][1] = SHIP;
    do_reset();
    press(M_A); @(negedge clk); @(negedge clk);
    total++; if (bc !== 3'd1 || turn !== 1'b1) begin bad++; $display("FAIL win_first bc=%0d turn=%b exp 1 1", bc, turn); end
    serve_cpu(3'd7, 3'd7);
    press(M_R);
    press(M_A); @(negedge clk); @(negedge clk);
    total++; if (game_over !== 1'b1 || winner !== 1'b0) begin bad++; $display("FAIL player_win go=%b win=%b exp 1 0", game_over, winner); end
    total++; if (bc !== 3'd0 || bus.cpu_req !== 1'b0) begin bad++; $display("FAIL player_win_state bc=%0d req=%b exp 0 0", bc, bus.cpu_req); end
    c0 = wr_count;
    press(M_A); press(M_R);
    bus.cpu_x = 3'd0; bus.cpu_y = 3'd0; bus.cpu_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.cpu_valid = 1'b0;
    total++; if (wr_count !== c0) begin bad++; $display("FAIL over_no_write got=%0d exp=%0d", wr_count, c0); end
    total++; if (game_over !== 1'b1 || px !== 3'd1) begin bad++; $display("FAIL over_hold go=%b x=%0d exp 1 1", game_over, px); end
  endtask

  task automatic test_cpu_win();
    clear_mem(); mem[0][0] = SHIP; mem[0][1] = SHIP; mem[0][5] = MISS;
    do_reset();
    serve_cpu(3'd0, 3'd0);
    total++; if (bj !== 3'd1 || turn !== 1'b0) begin bad++; $display("FAIL cpu_hit bj=%0d turn=%b exp 1 0", bj, turn); end
    serve_cpu(3'd5, 3'd0);
    total++; if (turn !== 1'b1 || bus.cpu_req !== 1'b1) begin bad++; $display("FAIL cpu_repeat turn=%b req=%b exp 1 1", turn, bus.cpu_req); end
    serve_cpu(3'd1, 3'd0);
    total++; if (game_over !== 1'b1 || winner !== 1'b1 || bj !== 3'd0) begin bad++; $display("FAIL cpu_win go=%b win=%b bj=%0d exp 1 1 0", game_over, winner, bj); end
  endtask

  task automatic test_attack_dir_reset();
    int c0;
    clear_mem(); mem[1][8] = SHIP;
    do_reset();
    press(M_D);
    c0 = wr_count;
    press(M_A | M_R);
    total++; if (px !== 3'd0 || py !== 3'd1) begin bad++; $display("FAIL atk_dir_cursor got=(%0d,%0d) exp=(0,1)", px, py); end
    total++; if (bus.board_sel !== 1'b1 || bus.board_addr !== 6'd8) begin bad++; $display("FAIL atk_dir_read sel=%b addr=%0d exp 1 8", bus.board_sel, bus.board_addr); end
    reset = 1'b1;
    #1;
    total++; if (bus.board_wr_en !== 1'b0 || bus.board_sel !== 1'b0 || bus.board_addr !== 6'd0) begin bad++; $display("FAIL abort_bus wr=%b sel=%b addr=%0d exp 0 0 0", bus.board_wr_en, bus.board_sel, bus.board_addr); end
    total++; if (py !== 3'd0 || px !== 3'd0 || turn !== 1'b0 || bc !== 3'd2 || bj !== 3'd2) begin bad++; $display("FAIL abort_state x=%0d y=%0d turn=%b bc=%0d bj=%0d exp 0 0 0 2 2", px, py, turn, bc, bj); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_count !== c0) begin bad++; $display("FAIL abort_no_write got=%0d exp=%0d", wr_count, c0); end
    total++; if (game_over !== 1'b0 || bus.cpu_req !== 1'b0) begin bad++; $display("FAIL abort_ctrl go=%b req=%b exp 0 0", game_over, bus.cpu_req); end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_attack_hit();
    test_repeat_miss();
    test_idle_cpu();
    test_player_win();
    test_cpu_win();
    test_attack_dir_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
